// File: rtl/instruction_fetch.sv
// RV32I instruction fetch stage: PC, async-read imem addressing and a
// 2-entry {pc, instr} buffer feeding decode over valid/ready.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault
);

    logic [31:0] r_fetch_pc;
    logic [31:0] r_pc    [2];
    logic [31:0] r_instr [2];
    logic        r_head;
    logic [1:0]  r_count;
    logic        r_fault;

    logic        w_pop;
    logic        w_cap;
    logic        w_redir;
    logic        w_tail;

    // Tail slot is head+count mod 2; with count=2 it aliases the head,
    // which is only written when that head is popped in the same cycle.
    assign w_tail   = r_head ^ r_count[0];
    assign w_redir  = redirect_valid & ~r_fault;
    assign w_pop    = id_valid & id_ready;
    assign w_cap    = ~r_fault & ~redirect_valid & ((r_count != 2'd2) | w_pop);

    assign imem_addr   = r_fetch_pc;
    assign id_valid    = (r_count != 2'd0) & ~r_fault;
    assign id_instr    = r_instr[r_head];
    assign id_pc       = r_pc[r_head];
    assign id_pc_plus4 = r_pc[r_head] + 32'd4;
    assign fetch_fault = r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_pc[0]    <= 32'd0;
            r_pc[1]    <= 32'd0;
            r_instr[0] <= 32'd0;
            r_instr[1] <= 32'd0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_fault    <= 1'b0;
        end else begin
            if (w_redir) begin
                r_count    <= 2'd0;
                r_fetch_pc <= redirect_target;
                if (redirect_target[1:0] != 2'b00) begin
                    r_fault <= 1'b1;
                end
            end else begin
                if (w_cap) begin
                    r_pc[w_tail]    <= r_fetch_pc;
                    r_instr[w_tail] <= imem_data;
                    r_fetch_pc      <= r_fetch_pc + 32'd4;
                end
                if (w_cap && !w_pop) begin
                    r_count <= r_count + 2'd1;
                end else if (!w_cap && w_pop) begin
                    r_count <= r_count - 2'd1;
                end
            end
            // A head popped in a redirect cycle still counts as transferred.
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: scoreboard of expected PCs,
// instruction words derived from a small behavioural memory.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_fault;

    int n_tests;
    int n_fail;
    logic [31:0] q [$];
    logic [31:0] exp_pc;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   mem = 32'h0400_0413;
            32'h4:   mem = 32'h0320_0493;
            32'h8:   mem = 32'h0000_0000;
            default: mem = a ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    assign imem_data = mem(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        id_ready = rdy;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        id_ready = 1'b0;
        #2;
        n_tests++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: valid=%b addr=%h fault=%b want 0/0/0",
                     id_valid, imem_addr, fetch_fault);
        end
        n_tests++;
        if (id_instr !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_head: instr=%h pc=%h p4=%h want 0/0/4",
                     id_instr, id_pc, id_pc_plus4);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        q.push_back(32'h0);
        q.push_back(32'h4);
        q.push_back(32'h8);
        q.push_back(32'hC);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_valid[%0d]: got %b want 1", i, id_valid);
            end
            if (id_valid && id_ready && q.size() > 0) begin
                exp_pc = q.pop_front();
                n_tests++;
                if (id_pc !== exp_pc || id_instr !== mem(exp_pc) ||
                    id_pc_plus4 !== exp_pc + 32'd4) begin
                    n_fail++;
                    $display("FAIL stream_item: pc=%h instr=%h p4=%h want pc=%h instr=%h",
                             id_pc, id_instr, id_pc_plus4, exp_pc, mem(exp_pc));
                end
            end
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_left: %0d items undelivered want 0", q.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                n_tests++;
                if (imem_addr !== 32'h8) begin
                    n_fail++;
                    $display("FAIL bp_fill: addr=%h want 00000008", imem_addr);
                end
            end
        end
        n_tests++;
        if (imem_addr !== 32'h8 || id_pc !== 32'h0 || id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: addr=%h pc=%h valid=%b want 8/0/1",
                     imem_addr, id_pc, id_valid);
        end
        id_ready = 1'b1;
        q.push_back(32'h0);
        q.push_back(32'h4);
        q.push_back(32'h8);
        q.push_back(32'hC);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_gap[%0d]: valid=%b want 1", i, id_valid);
            end
            if (id_valid && id_ready && q.size() > 0) begin
                exp_pc = q.pop_front();
                n_tests++;
                if (id_pc !== exp_pc || id_instr !== mem(exp_pc)) begin
                    n_fail++;
                    $display("FAIL bp_item: pc=%h instr=%h want pc=%h instr=%h",
                             id_pc, id_instr, exp_pc, mem(exp_pc));
                end
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_left: %0d items undelivered want 0", q.size());
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h18;
        @(posedge clk);
        #1;
        n_tests++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h18) begin
            n_fail++;
            $display("FAIL redir_flush: valid=%b addr=%h want 0/00000018",
                     id_valid, imem_addr);
        end
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        q.push_back(32'h18);
        q.push_back(32'h1C);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL redir_valid[%0d]: got %b want 1", i, id_valid);
            end
            if (id_valid && id_ready && q.size() > 0) begin
                exp_pc = q.pop_front();
                n_tests++;
                if (id_pc !== exp_pc || id_instr !== mem(exp_pc)) begin
                    n_fail++;
                    $display("FAIL redir_item: pc=%h instr=%h want pc=%h instr=%h",
                             id_pc, id_instr, exp_pc, mem(exp_pc));
                end
            end
        end
    endtask

    task automatic test_redirect_pop();
        do_reset(1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h24;
        q.push_back(32'h0);
        if (id_valid && id_ready && q.size() > 0) begin
            exp_pc = q.pop_front();
            n_tests++;
            if (id_pc !== exp_pc || id_instr !== mem(exp_pc)) begin
                n_fail++;
                $display("FAIL rpop_head: pc=%h instr=%h want pc=%h", id_pc, id_instr, exp_pc);
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        n_tests++;
        if (id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rpop_flush: valid=%b want 0", id_valid);
        end
        q.push_back(32'h24);
        q.push_back(32'h28);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (id_valid && id_ready && q.size() > 0) begin
                exp_pc = q.pop_front();
                n_tests++;
                if (id_pc !== exp_pc || id_instr !== mem(exp_pc)) begin
                    n_fail++;
                    $display("FAIL rpop_item: pc=%h instr=%h want pc=%h", id_pc, id_instr, exp_pc);
                end
            end
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL rpop_left: %0d items undelivered want 0", q.size());
        end
    endtask

    task automatic test_misaligned();
        do_reset(1'b1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_target = 32'h22;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        n_tests++;
        if (fetch_fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 32'h22) begin
            n_fail++;
            $display("FAIL mis_fault: fault=%b valid=%b addr=%h want 1/0/00000022",
                     fetch_fault, id_valid, imem_addr);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h22) begin
            n_fail++;
            $display("FAIL mis_stall: valid=%b addr=%h want 0/00000022", id_valid, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        n_tests++;
        if (imem_addr !== 32'h22 || fetch_fault !== 1'b1 || id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_ignore: addr=%h fault=%b valid=%b want 00000022/1/0",
                     imem_addr, fetch_fault, id_valid);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (fetch_fault !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL mis_clear: fault=%b addr=%h want 0/0", fetch_fault, imem_addr);
        end
        do_reset(1'b1);
        @(posedge clk);
        #1;
        n_tests++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0400_0413) begin
            n_fail++;
            $display("FAIL mis_restart: valid=%b pc=%h instr=%h want 1/0/04000413",
                     id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_wrap_async();
        do_reset(1'b1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        q.push_back(32'hFFFF_FFFC);
        q.push_back(32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (imem_addr !== 32'h4 * i) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d]: addr=%h want %h", i, imem_addr, 32'h4 * i);
            end
            if (id_valid && id_ready && q.size() > 0) begin
                exp_pc = q.pop_front();
                n_tests++;
                if (id_pc !== exp_pc || id_pc_plus4 !== exp_pc + 32'd4 ||
                    id_instr !== mem(exp_pc)) begin
                    n_fail++;
                    $display("FAIL wrap_item: pc=%h p4=%h instr=%h want pc=%h p4=%h",
                             id_pc, id_pc_plus4, id_instr, exp_pc, exp_pc + 32'd4);
                end
            end
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_left: %0d items undelivered want 0", q.size());
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst: valid=%b addr=%h want 0/0", id_valid, imem_addr);
        end
        do_reset(1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_misaligned();
        test_wrap_async();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the RV32I core. Owns the program counter, drives the address of the asynchronous-read instruction memory, and captures each returned word together with its PC into a 2-entry buffer. It presents fetched instructions to decode over a valid/ready handshake and accepts PC redirects from execute for taken branches and jumps.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  32  fetch address to instruction memory; equals internal fetch_pc
- imem_data  in  32  instruction word, valid combinationally in the same cycle as imem_addr
- redirect_valid  in  1  taken branch/jump from execute
- redirect_target  in  32  new fetch address when redirect_valid=1
- id_ready  in  1  decode can accept an instruction this cycle
- id_valid  out  1  buffer head holds a valid instruction
- id_instr  out  32  instruction at buffer head
- id_pc  out  32  PC of id_instr
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32
- fetch_fault  out  1  sticky; set on misaligned redirect

## Operation
- State: fetch_pc (32), a 2-entry FIFO of {pc, instr}, count (0..2), fault flag.
- pop = id_valid & id_ready. A popped head counts as transferred, including in a redirect cycle; killing wrong-path instructions is the pipeline's job.
- cap = !fault & !redirect_valid & (count<2 | pop). On cap: push {fetch_pc, imem_data}; fetch_pc <= fetch_pc + 4, with 32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000.
- Full (count=2) with no pop: no capture; fetch_pc and imem_addr hold.
- Full with pop: pop and push in the same cycle; count stays 2.
- Redirect with aligned target (target[1:0]=0): FIFO flushed (count<=0), fetch_pc <=redirect_target, no capture that cycle. Redirect takes priority over capture and over FIFO ordering.
- Redirect with misaligned target: same flush, fetch_pc <= target, fault <= 1. While fault=1: no captures, id_valid=0, redirects ignored. Only rst clears fault.
- id_valid = (count != 0). id_instr, id_pc and id_pc_plus4 come from the FIFO head and are stable while id_valid=1 & id_ready=0.
- Instruction contents are not interpreted. An all-zero word is buffered like any other word.

## Timing
- Reset values: fetch_pc=RESET_PC, imem_addr=RESET_PC, count=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4, fetch_fault=0.
- rst asserted mid-operation clears everything immediately (asynchronous reset), including an in-flight redirect.
- Fetch latency: the word at imem_addr is captured at the next rising edge and seen on id_* during the following cycle. First id_valid=1 is in the first cycle after the first post-reset edge.
- Redirect latency: redirect_valid sampled at edge N. imem_addr=target after N, and id_valid=0 for that cycle. The target instruction appears on id_* after edge N+1.
- Throughput: 1 instruction/cycle with id_ready held high.
- Backpressure: id_ready low for k cycles fills the FIFO after 2 edges. Further fetch stalls until a pop. No instruction is dropped or duplicated.

## Test plan
- Reset and stream: release rst, id_ready=1, memory holds 0x04000413 at 0 and 0x03200493 at 4 -> id_valid=1 with (pc 0, 0x04000413) after edge 1, then (pc 4, 0x03200493) after edge 2, id_pc_plus4=8; one instruction per cycle.
- Backpressure: id_ready=0 for 5 cycles from reset -> count saturates at 2, imem_addr holds 8, head remains pc 0. Raise id_ready -> pcs 0, 4, 8, 12 delivered in order with no gaps or duplicates.
- Redirect: during streaming, assert redirect_valid with target 0x18 for one cycle while FIFO holds 2 entries -> FIFO flushed, id_valid=0 for one cycle, next delivered pc=0x18, then 0x1C.
- Simultaneous redirect and pop: full FIFO, id_ready=1, redirect to 0x24 -> head counted as popped, second entry discarded, next delivered pc=0x24.
- Misaligned redirect: target 0x22 -> fetch_fault=1 after edge, id_valid=0, no further captures; a later aligned redirect has no effect; rst clears fault and restarts at RESET_PC.
- Wrap and async reset: redirect to 0xFFFF_FFFC -> delivered pcs 0xFFFF_FFFC then 0x0000_0000, with id_pc_plus4=0 for the first. Assert rst between clock edges -> id_valid drops to 0 and imem_addr=RESET_PC without waiting for an edge.
